// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage: default widths, reset PC,
// FSM encodings and the sequential PC step.
package inst_fetch_pkg;
  localparam int          ADDR_W_DEF   = 32;
  localparam int          INSTR_W_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [0:0]  FETCH_IDLE   = 1'b0;
  localparam logic [0:0]  FETCH_RUN    = 1'b1;

  localparam int          PC_INC       = 4;
endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Flush wins over push; a full FIFO still accepts a push when it pops too.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited in-order word fetches
// and queues PC-tagged instructions for decode; redirects flush via a drop counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  // Drop can accumulate over several redirects while stale responses are still out.
  localparam int DW = CW + 4;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc, resp_pc, redir_pc;
  logic [CW-1:0]     inflight, count;
  logic [DW-1:0]     drop;
  logic              req_fire, resp_acc, resp_drop, push, pop, full, empty;

  assign redir_pc       = redirect_pc & ~ADDR_W'(3);
  assign imem_req_valid = (state == FETCH_RUN) && !redirect_valid &&
                          (int'(inflight) + int'(count) < DEPTH);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding predates the last reset and is ignored.
  assign resp_acc  = imem_resp_valid && ((drop != '0) || (inflight != '0));
  assign resp_drop = resp_acc && (drop != '0);
  assign push      = resp_acc && (drop == '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_valid = !empty;

  fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({resp_pc, imem_resp_data}),
    .rdata ({dec_pc, dec_instr}),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state <= FETCH_RUN;
      if (redirect_valid) begin
        pc       <= redir_pc;
        resp_pc  <= redir_pc;
        inflight <= '0;
        drop     <= drop + DW'(inflight) + DW'(req_fire) - DW'(resp_acc);
      end else begin
        if (req_fire) pc      <= pc + ADDR_W'(PC_INC);
        if (push)     resp_pc <= resp_pc + ADDR_W'(PC_INC);
        inflight <= inflight + CW'(req_fire) - CW'(push);
        if (resp_drop) drop <= drop - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full && !pop));
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: an in-order memory model with variable
// latency, expected decode PCs queued on request acceptance.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;

  inst_fetch #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } mresp_t;
  mresp_t      memq[$];
  logic [31:0] sb[$];

  int          errors = 0, checks = 0, cyc = 0, lat = 1, nreq = 0, ndec = 0;
  logic [31:0] exp_pc = 32'h0, last_req_addr = 32'h0, last_dec_pc = 32'h0;
  logic        r_reset = 1'b1, r_req_ready = 1'b1, r_dec_ready = 1'b1, r_redirect = 1'b0;
  logic [31:0] r_redirect_pc = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // One cycle: drive inputs after negedge, then sample and score the cycle.
  task automatic step();
    logic [31:0] e;
    mresp_t      m;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memq[0].data;
      void'(memq.pop_front());
    end
    reset          = r_reset;
    imem_req_ready = r_req_ready;
    dec_ready      = r_dec_ready;
    redirect_valid = r_redirect;
    redirect_pc    = r_redirect_pc;
    #1;
    if (r_reset) begin
      sb.delete();
      memq.delete();
      exp_pc = 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h (cycle %0d)", imem_req_addr, exp_pc, cyc);
        end
        m.data = memfn(imem_req_addr);
        m.due  = cyc + lat;
        memq.push_back(m);
        sb.push_back(exp_pc);
        exp_pc        = exp_pc + 32'd4;
        last_req_addr = imem_req_addr;
        nreq++;
      end
      if (dec_valid && dec_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dec_unexpected: got pc %h expected no instruction (cycle %0d)", dec_pc, cyc);
        end else begin
          e = sb.pop_front();
          if (dec_pc !== e || dec_instr !== memfn(e)) begin
            errors++;
            $display("FAIL dec_out: got pc %h instr %h expected pc %h instr %h (cycle %0d)",
                     dec_pc, dec_instr, e, memfn(e), cyc);
          end
        end
        last_dec_pc = dec_pc;
        ndec++;
      end
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & ~32'd3;
      end
    end
    r_redirect = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int l);
    lat = l; r_req_ready = 1'b1; r_dec_ready = 1'b1; r_redirect = 1'b0;
    r_reset = 1'b1; step(); step();
    r_reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    r_req_ready = 1'b0; r_dec_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && memq.size() == 0) break;
      step();
    end
    run(3);
  endtask

  task automatic wait_dec(input int n0, output logic got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (ndec > n0) got = 1'b1;
    end
  endtask

  task automatic wait_req(input int n0, input int k, output logic got);
    got = (nreq - n0 >= k);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (nreq - n0 >= k) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset(1);
    step();
    checks++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got req_valid %b dec_valid %b expected 0 0", imem_req_valid, dec_valid);
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got valid %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    int n0;
    run(2);
    n0 = ndec;
    run(16);
    checks++;
    if (ndec - n0 !== 16 || last_dec_pc !== 32'h40) begin
      errors++;
      $display("FAIL throughput: got %0d decodes last pc %h expected 16 decodes last pc 00000040",
               ndec - n0, last_dec_pc);
    end
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int n0;
    logic got;
    do_reset(1);
    r_dec_ready = 1'b0;
    n0 = nreq;
    run(12);
    checks++;
    if (nreq - n0 !== 4 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_limit: got %0d reqs valid %b expected 4 reqs valid 0", nreq - n0, imem_req_valid);
    end
    r_dec_ready = 1'b1;
    n0 = ndec;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (ndec - n0 >= 5) got = 1'b1;
    end
    checks++;
    if (!got || last_dec_pc !== 32'h10) begin
      errors++;
      $display("FAIL resume_pc: got pc %h (done %b) expected 00000010", last_dec_pc, got);
    end
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] a0;
    do_reset(1);
    run(6);
    r_req_ready = 1'b0;
    step();
    a0 = imem_req_addr;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
        errors++;
        $display("FAIL addr_hold: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, a0);
      end
    end
    r_req_ready = 1'b1;
    run(8);
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL stall_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_redirect_inflight();
    int n0;
    logic got;
    do_reset(3);
    n0 = nreq;
    wait_req(n0, 2, got);
    r_req_ready = 1'b0;
    r_redirect = 1'b1; r_redirect_pc = 32'h103;
    step();
    r_req_ready = 1'b1;
    n0 = nreq;
    wait_req(n0, 1, got);
    checks++;
    if (!got || last_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_req: got addr %h (seen %b) expected 00000100", last_req_addr, got);
    end
    wait_dec(ndec, got);
    checks++;
    if (!got || last_dec_pc !== 32'h100) begin
      errors++;
      $display("FAIL redir_dec: got pc %h (seen %b) expected 00000100", last_dec_pc, got);
    end
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL redir_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_redirect_pop();
    int n0;
    logic got;
    do_reset(1);
    run(6);
    n0 = ndec;
    r_redirect = 1'b1; r_redirect_pc = 32'h200;
    step();
    checks++;
    if (dec_valid !== 1'b1 || imem_resp_valid !== 1'b1 || ndec - n0 !== 1) begin
      errors++;
      $display("FAIL redir_pop: got dec_valid %b resp %b pops %0d expected 1 1 1",
               dec_valid, imem_resp_valid, ndec - n0);
    end
    step();
    checks++;
    if (dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: got dec_valid %b expected 0", dec_valid);
    end
    wait_dec(ndec, got);
    checks++;
    if (!got || last_dec_pc !== 32'h200) begin
      errors++;
      $display("FAIL redir_pop_target: got pc %h (seen %b) expected 00000200", last_dec_pc, got);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic got;
    do_reset(3);
    run(5);
    r_redirect = 1'b1; r_redirect_pc = 32'h300;
    step();
    r_redirect = 1'b1; r_redirect_pc = 32'h402;
    step();
    wait_dec(ndec, got);
    checks++;
    if (!got || last_dec_pc !== 32'h400) begin
      errors++;
      $display("FAIL b2b_target: got pc %h (seen %b) expected 00000400", last_dec_pc, got);
    end
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_wrap_and_reset();
    int n0;
    logic got;
    do_reset(1);
    run(4);
    r_redirect = 1'b1; r_redirect_pc = 32'hFFFF_FFF8;
    step();
    n0 = nreq;
    wait_req(n0, 3, got);
    checks++;
    if (!got || last_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got addr %h (seen %b) expected 00000000", last_req_addr, got);
    end
    run(4);
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
    step();
    checks++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got dec_valid %b req_valid %b expected 0 0", dec_valid, imem_req_valid);
    end
    n0 = nreq;
    wait_req(n0, 1, got);
    checks++;
    if (!got || last_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL midreset_refetch: got addr %h (seen %b) expected 00000000", last_req_addr, got);
    end
    run(6);
    drain();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL wrap_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
